riscv_wb_arbiter: RTL and testbench
===================================

Name: riscv_wb_arbiter

Overview:
- Write-back arbiter that produces the two write ports (A, B) of the integer/FP register file.
- Merges three result producers:
  - ALU: single-cycle.
  - LSU load data: single-cycle, highest priority.
  - FPU/iterative unit: multi-cycle; results are buffered in a FIFO.
- Keeps a per-register pending-write scoreboard that decode uses to stall on RAW/WAW hazards against outstanding FPU results.

Parameters:
ADDR_WIDTH, 6, register address width; bit 5 selects FP bank; NUM_REGS = 2**ADDR_WIDTH.
DATA_WIDTH, 32, result data width.
FIFO_DEPTH, 2, FPU result buffer entries; power of two, minimum 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lsu_valid_i  in  1  LSU load result valid; always accepted
lsu_waddr_i  in  ADDR_WIDTH  LSU destination register
lsu_wdata_i  in  DATA_WIDTH  LSU result
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU result accepted this cycle
alu_waddr_i  in  ADDR_WIDTH  ALU destination register
alu_wdata_i  in  DATA_WIDTH  ALU result
fpu_issue_i  in  1  FPU op issued; mark destination pending
fpu_issue_waddr_i  in  ADDR_WIDTH  destination of issued FPU op
fpu_valid_i  in  1  FPU result valid
fpu_ready_o  out  1  FIFO can accept FPU result
fpu_waddr_i  in  ADDR_WIDTH  FPU destination register
fpu_wdata_i  in  DATA_WIDTH  FPU result
we_a_o  out  1  register file write enable, port A
waddr_a_o  out  ADDR_WIDTH  register file write address, port A
wdata_a_o  out  DATA_WIDTH  register file write data, port A
we_b_o  out  1  register file write enable, port B
waddr_b_o  out  ADDR_WIDTH  register file write address, port B
wdata_b_o  out  DATA_WIDTH  register file write data, port B
busy_o  out  NUM_REGS  pending FPU write per register
fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs driven by flops clear to 0. This covers we_a_o, we_b_o, both addresses and data, busy_o, FIFO pointers and count. fpu_ready_o is 1 out of reset.
- Accept/ready:
  - fpu_ready_o = (fifo_cnt < FIFO_DEPTH); a handshake occurs when fpu_valid_i & fpu_ready_o.
  - alu_ready_o = ~(FIFO full); combinational from registered state only.
- Port B (registered, 1-cycle latency): at the next edge, we_b_o <= lsu_valid_i, and waddr_b_o/wdata_b_o <= the LSU fields. LSU is never stalled.
- Port A source selection, registered, 1-cycle latency:
  - FIFO full: the FIFO head is popped to port A; the ALU is not accepted.
  - Else if alu_valid_i: the ALU goes to port A; the FIFO holds.
  - Else if the FIFO is non-empty: the head is popped to port A.
  - Else: we_a_o <= 0.
- Address 0:
  - Any write to address 0 yields we=0 on that port.
  - A FIFO entry popped with address 0 still frees its slot and clears nothing.
- Same address on A and B in one cycle: both are presented; the register file gives port B precedence, so LSU data wins.
- FIFO:
  - Push and pop in the same cycle while full: the pop frees a slot combinationally-late, so the push is refused (ready was 0). The count stays at FIFO_DEPTH - 1 + 0 = one less.
  - Push and pop in the same cycle when neither full nor empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - fpu_issue_i with a nonzero address sets busy[addr] at the next edge.
  - A FIFO pop clears busy[addr] at the same edge at which we_a_o is registered high.
  - Same-cycle set and clear of the same index: set wins.
  - Issue to an already-busy register is a protocol violation; the bench asserts on it and the RTL keeps the bit at 1.
  - busy[0] is always 0.
- Reset mid-operation: FIFO contents are discarded, busy_o is cleared, and write enables are deasserted asynchronously.
- No combinational path from any *_i to any register-file output.

Test Plan:
- Reset release, idle → we_a_o=we_b_o=0, busy_o=0, fpu_ready_o=1, fifo_cnt_o=0.
- LSU write to r5 = 0xDEADBEEF and ALU write to r5 = 0x11111111 in the same cycle → next cycle we_a_o=we_b_o=1, waddr_a_o=waddr_b_o=5, wdata_b_o=0xDEADBEEF; a register file read of r5 two cycles later returns 0xDEADBEEF.
- fpu_issue to r33, then FPU result r33 = 0x3F800000 with ALU idle → busy_o[33]=1 after issue; port A writes r33 one cycle after the handshake; busy_o[33]=0 on the same edge.
- Two FPU results pushed while ALU is valid every cycle → FIFO full, fpu_ready_o=0, alu_ready_o=0. Next cycle the head drains to port A and the ALU is accepted the cycle after. Data order is preserved.
- fpu_issue to r40 in the same cycle a popped FIFO entry clears r40 → busy_o[40]=1 after the edge.
- Assert rst_n low while FIFO holds 2 entries and busy_o[34]=1 → outputs cleared immediately; after release no stale write appears on port A.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
// Write-back arbiter for the two register-file write ports.
//   Port B : LSU load results, never stalled, 1-cycle registered.
//   Port A : ALU results or buffered FPU results, 1-cycle registered.
//            A full FPU FIFO takes precedence over the ALU. Otherwise the
//            ALU wins and the FIFO drains only on ALU-idle cycles.
//   busy_o : per-register pending-write scoreboard for FPU destinations.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   lsu_valid_i/waddr_i/wdata_i    LSU result (always accepted)
//   alu_valid_i/waddr_i/wdata_i    ALU result, alu_ready_o = accepted
//   fpu_issue_i/fpu_issue_waddr_i  FPU issue, marks destination busy
//   fpu_valid_i/waddr_i/wdata_i    FPU result, fpu_ready_o = FIFO not full
//   we/waddr/wdata_{a,b}_o         register-file write ports
//   busy_o                         pending FPU writes, one bit per register
//   fifo_cnt_o                     FPU FIFO occupancy
module riscv_wb_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2,
   localparam int NUM_REGS  = 2**ADDR_WIDTH,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lsu_valid_i,
   input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   input  logic                  alu_valid_i,
   output logic                  alu_ready_o,
   input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
   input  logic [DATA_WIDTH-1:0] alu_wdata_i,
   input  logic                  fpu_issue_i,
   input  logic [ADDR_WIDTH-1:0] fpu_issue_waddr_i,
   input  logic                  fpu_valid_i,
   output logic                  fpu_ready_o,
   input  logic [ADDR_WIDTH-1:0] fpu_waddr_i,
   input  logic [DATA_WIDTH-1:0] fpu_wdata_i,
   output logic                  we_a_o,
   output logic [ADDR_WIDTH-1:0] waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_b_o,
   output logic [ADDR_WIDTH-1:0] waddr_b_o,
   output logic [DATA_WIDTH-1:0] wdata_b_o,
   output logic [NUM_REGS-1:0]   busy_o,
   output logic [CW-1:0]         fifo_cnt_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_cnt;
   logic [NUM_REGS-1:0]   r_busy;

   logic                  r_we_a;
   logic [ADDR_WIDTH-1:0] r_waddr_a;
   logic [DATA_WIDTH-1:0] r_wdata_a;
   logic                  r_we_b;
   logic [ADDR_WIDTH-1:0] r_waddr_b;
   logic [DATA_WIDTH-1:0] r_wdata_b;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_head_addr;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic [NUM_REGS-1:0]   w_busy_nxt;

   assign w_full      = (r_cnt == DEPTH_C);
   assign w_empty     = (r_cnt == '0);
   assign w_head_addr = r_fifo_addr[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   // Ready is derived from registered occupancy only; a same-cycle pop
   // while full does not open a slot for a push.
   assign w_push = fpu_valid_i & ~w_full;
   assign w_pop  = w_full | (~alu_valid_i & ~w_empty);

   assign fpu_ready_o = ~w_full;
   assign alu_ready_o = ~w_full;

   // Pop clears first so that a same-cycle issue to the same index wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop)
         w_busy_nxt[w_head_addr] = 1'b0;
      if (fpu_issue_i && (fpu_issue_waddr_i != '0))
         w_busy_nxt[fpu_issue_waddr_i] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // FIFO storage needs no reset; occupancy is tracked by r_cnt.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= fpu_waddr_i;
         r_fifo_data[r_wr_ptr] <= fpu_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_cnt     <= '0;
         r_busy    <= '0;
         r_we_a    <= 1'b0;
         r_waddr_a <= '0;
         r_wdata_a <= '0;
         r_we_b    <= 1'b0;
         r_waddr_b <= '0;
         r_wdata_b <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         r_busy <= w_busy_nxt;

         if (w_pop) begin
            r_we_a    <= (w_head_addr != '0);
            r_waddr_a <= w_head_addr;
            r_wdata_a <= w_head_data;
         end else if (alu_valid_i) begin
            r_we_a    <= (alu_waddr_i != '0);
            r_waddr_a <= alu_waddr_i;
            r_wdata_a <= alu_wdata_i;
         end else begin
            r_we_a    <= 1'b0;
         end

         r_we_b    <= lsu_valid_i & (lsu_waddr_i != '0);
         r_waddr_b <= lsu_waddr_i;
         r_wdata_b <= lsu_wdata_i;
      end
   end

   assign we_a_o     = r_we_a;
   assign waddr_a_o  = r_waddr_a;
   assign wdata_a_o  = r_wdata_a;
   assign we_b_o     = r_we_b;
   assign waddr_b_o  = r_waddr_b;
   assign wdata_b_o  = r_wdata_b;
   assign busy_o     = r_busy;
   assign fifo_cnt_o = r_cnt;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
module tb_riscv_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid_i;
   logic [5:0]  lsu_waddr_i;
   logic [31:0] lsu_wdata_i;
   logic        alu_valid_i;
   logic        alu_ready_o;
   logic [5:0]  alu_waddr_i;
   logic [31:0] alu_wdata_i;
   logic        fpu_issue_i;
   logic [5:0]  fpu_issue_waddr_i;
   logic        fpu_valid_i;
   logic        fpu_ready_o;
   logic [5:0]  fpu_waddr_i;
   logic [31:0] fpu_wdata_i;
   logic        we_a_o;
   logic [5:0]  waddr_a_o;
   logic [31:0] wdata_a_o;
   logic        we_b_o;
   logic [5:0]  waddr_b_o;
   logic [31:0] wdata_b_o;
   logic [63:0] busy_o;
   logic [1:0]  fifo_cnt_o;

   int checks = 0;
   int failures = 0;
   logic allow_reissue = 1'b0;
   logic [31:0] rf [64];

   riscv_wb_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
      .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
      .fpu_issue_i(fpu_issue_i), .fpu_issue_waddr_i(fpu_issue_waddr_i),
      .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
      .fpu_waddr_i(fpu_waddr_i), .fpu_wdata_i(fpu_wdata_i),
      .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
      .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
      .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o)
   );

   always #5 clk = ~clk;

   // Register file: port B written last, so it wins on a shared address.
   always @(posedge clk) begin
      if (we_a_o) rf[waddr_a_o] <= wdata_a_o;
      if (we_b_o) rf[waddr_b_o] <= wdata_b_o;
   end

   // Protocol monitor: issuing to a register that is still busy.
   always @(posedge clk) begin
      if (rst_n && fpu_issue_i && fpu_issue_waddr_i != 6'd0 && !allow_reissue) begin
         checks++;
         assert (busy_o[fpu_issue_waddr_i] == 1'b0)
         else begin
            failures++;
            $display("FAIL issue_to_busy: r%0d busy=%0b required 0",
                     fpu_issue_waddr_i, busy_o[fpu_issue_waddr_i]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
      alu_valid_i = 0; alu_waddr_i = 0; alu_wdata_i = 0;
      fpu_issue_i = 0; fpu_issue_waddr_i = 0;
      fpu_valid_i = 0; fpu_waddr_i = 0; fpu_wdata_i = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      step(); step();
      rst_n = 1;
      step();
      checks++;
      if ({we_a_o, we_b_o} !== 2'b00) begin
         failures++; $display("FAIL reset_we: got %b required 00", {we_a_o, we_b_o});
      end
      checks++;
      if (busy_o !== 64'd0) begin
         failures++; $display("FAIL reset_busy: got %h required 0", busy_o);
      end
      checks++;
      if ({fpu_ready_o, alu_ready_o, fifo_cnt_o} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_ready_cnt: got fr=%b ar=%b cnt=%0d required 1 1 0",
                  fpu_ready_o, alu_ready_o, fifo_cnt_o);
      end
   endtask

   task automatic test_same_addr();
      lsu_valid_i = 1; lsu_waddr_i = 6'd5; lsu_wdata_i = 32'hDEADBEEF;
      alu_valid_i = 1; alu_waddr_i = 6'd5; alu_wdata_i = 32'h11111111;
      step();
      idle_inputs();
      checks++;
      if ({we_a_o, we_b_o, waddr_a_o, waddr_b_o} !== {2'b11, 6'd5, 6'd5}) begin
         failures++;
         $display("FAIL same_addr_ports: got we=%b%b a=%0d b=%0d required 11 5 5",
                  we_a_o, we_b_o, waddr_a_o, waddr_b_o);
      end
      checks++;
      if (wdata_a_o !== 32'h11111111 || wdata_b_o !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL same_addr_data: got a=%h b=%h required 11111111 deadbeef",
                  wdata_a_o, wdata_b_o);
      end
      step();
      checks++;
      if (rf[5] !== 32'hDEADBEEF) begin
         failures++; $display("FAIL same_addr_rf: r5=%h required deadbeef", rf[5]);
      end
      // writes to r0 must be suppressed on both ports
      lsu_valid_i = 1; lsu_waddr_i = 6'd0; lsu_wdata_i = 32'h5;
      alu_valid_i = 1; alu_waddr_i = 6'd0; alu_wdata_i = 32'h6;
      step();
      idle_inputs();
      checks++;
      if ({we_a_o, we_b_o} !== 2'b00) begin
         failures++; $display("FAIL addr0_we: got %b required 00", {we_a_o, we_b_o});
      end
   endtask

   task automatic test_fpu_single();
      fpu_issue_i = 1; fpu_issue_waddr_i = 6'd33;
      step();
      idle_inputs();
      checks++;
      if (busy_o !== (64'd1 << 33)) begin
         failures++; $display("FAIL fpu_busy_set: got %h required %h", busy_o, 64'd1 << 33);
      end
      fpu_valid_i = 1; fpu_waddr_i = 6'd33; fpu_wdata_i = 32'h3F800000;
      checks++;
      if (fpu_ready_o !== 1'b1) begin
         failures++; $display("FAIL fpu_ready: got %b required 1", fpu_ready_o);
      end
      step();
      idle_inputs();
      checks++;
      if (fifo_cnt_o !== 2'd1 || we_a_o !== 1'b0) begin
         failures++;
         $display("FAIL fpu_push: got cnt=%0d we_a=%b required 1 0", fifo_cnt_o, we_a_o);
      end
      step();
      checks++;
      if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd33, 32'h3F800000}) begin
         failures++;
         $display("FAIL fpu_write: got we=%b a=%0d d=%h required 1 33 3f800000",
                  we_a_o, waddr_a_o, wdata_a_o);
      end
      checks++;
      if (busy_o !== 64'd0 || fifo_cnt_o !== 2'd0) begin
         failures++;
         $display("FAIL fpu_clear: got busy=%h cnt=%0d required 0 0", busy_o, fifo_cnt_o);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 3; i++) begin
         fpu_issue_i = 1; fpu_issue_waddr_i = 6'(34 + i);
         step();
      end
      idle_inputs();
      // E1: push F0, ALU A0 accepted
      alu_valid_i = 1; alu_waddr_i = 6'd1; alu_wdata_i = 32'hA0;
      fpu_valid_i = 1; fpu_waddr_i = 6'd34; fpu_wdata_i = 32'hF0;
      step();
      checks++;
      if ({we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o} !== {1'b1, 6'd1, 32'hA0, 2'd1}) begin
         failures++;
         $display("FAIL full_e1: got we=%b a=%0d d=%h cnt=%0d required 1 1 a0 1",
                  we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o);
      end
      // E2: push F1, ALU A1 accepted -> FIFO full
      alu_waddr_i = 6'd2; alu_wdata_i = 32'hA1;
      fpu_waddr_i = 6'd35; fpu_wdata_i = 32'hF1;
      step();
      checks++;
      if ({fpu_ready_o, alu_ready_o, fifo_cnt_o, waddr_a_o, wdata_a_o} !==
          {2'b00, 2'd2, 6'd2, 32'hA1}) begin
         failures++;
         $display("FAIL full_e2: got fr=%b ar=%b cnt=%0d a=%0d d=%h required 0 0 2 2 a1",
                  fpu_ready_o, alu_ready_o, fifo_cnt_o, waddr_a_o, wdata_a_o);
      end
      // E3: full -> pop F0, ALU stalled, F2 push refused
      alu_waddr_i = 6'd3; alu_wdata_i = 32'hA2;
      fpu_waddr_i = 6'd36; fpu_wdata_i = 32'hF2;
      step();
      checks++;
      if ({we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o} !== {1'b1, 6'd34, 32'hF0, 2'd1}) begin
         failures++;
         $display("FAIL full_e3: got we=%b a=%0d d=%h cnt=%0d required 1 34 f0 1",
                  we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o);
      end
      checks++;
      if (busy_o !== ((64'd1 << 35) | (64'd1 << 36)) || alu_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL full_e3_busy: got busy=%h ar=%b required %h 1",
                  busy_o, alu_ready_o, (64'd1 << 35) | (64'd1 << 36));
      end
      // E4: ALU A2 accepted, F2 pushed
      step();
      idle_inputs();
      checks++;
      if ({we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o} !== {1'b1, 6'd3, 32'hA2, 2'd2}) begin
         failures++;
         $display("FAIL full_e4: got we=%b a=%0d d=%h cnt=%0d required 1 3 a2 2",
                  we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o);
      end
      // E5, E6: drain F1 then F2 in order
      step();
      checks++;
      if ({waddr_a_o, wdata_a_o, fifo_cnt_o} !== {6'd35, 32'hF1, 2'd1}
          || busy_o !== (64'd1 << 36)) begin
         failures++;
         $display("FAIL full_e5: got a=%0d d=%h cnt=%0d busy=%h required 35 f1 1 %h",
                  waddr_a_o, wdata_a_o, fifo_cnt_o, busy_o, 64'd1 << 36);
      end
      step();
      checks++;
      if ({we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o} !== {1'b1, 6'd36, 32'hF2, 2'd0}
          || busy_o !== 64'd0) begin
         failures++;
         $display("FAIL full_e6: got we=%b a=%0d d=%h cnt=%0d busy=%h required 1 36 f2 0 0",
                  we_a_o, waddr_a_o, wdata_a_o, fifo_cnt_o, busy_o);
      end
      step();
      checks++;
      if (we_a_o !== 1'b0) begin
         failures++; $display("FAIL full_idle: we_a=%b required 0", we_a_o);
      end
   endtask

   task automatic test_set_clear();
      fpu_issue_i = 1; fpu_issue_waddr_i = 6'd40;
      step();
      idle_inputs();
      fpu_valid_i = 1; fpu_waddr_i = 6'd40; fpu_wdata_i = 32'h40;
      step();
      idle_inputs();
      // head pops this cycle while r40 is re-issued
      allow_reissue = 1;
      fpu_issue_i = 1; fpu_issue_waddr_i = 6'd40;
      step();
      idle_inputs();
      allow_reissue = 0;
      checks++;
      if ({we_a_o, waddr_a_o} !== {1'b1, 6'd40} || busy_o !== (64'd1 << 40)) begin
         failures++;
         $display("FAIL set_wins: got we=%b a=%0d busy=%h required 1 40 %h",
                  we_a_o, waddr_a_o, busy_o, 64'd1 << 40);
      end
      fpu_valid_i = 1; fpu_waddr_i = 6'd40; fpu_wdata_i = 32'h41;
      step();
      idle_inputs();
      step();
      checks++;
      if (busy_o !== 64'd0 || wdata_a_o !== 32'h41) begin
         failures++;
         $display("FAIL set_then_clear: got busy=%h d=%h required 0 41", busy_o, wdata_a_o);
      end
   endtask

   task automatic test_reset_mid();
      fpu_issue_i = 1; fpu_issue_waddr_i = 6'd34;
      step();
      idle_inputs();
      alu_valid_i = 1; alu_waddr_i = 6'd7; alu_wdata_i = 32'h77;
      lsu_valid_i = 1; lsu_waddr_i = 6'd8; lsu_wdata_i = 32'h88;
      fpu_valid_i = 1; fpu_waddr_i = 6'd34; fpu_wdata_i = 32'hC0;
      step();
      fpu_waddr_i = 6'd37; fpu_wdata_i = 32'hC1;
      step();
      idle_inputs();
      checks++;
      if ({fifo_cnt_o, we_a_o, we_b_o, busy_o[34]} !== {2'd2, 3'b111}) begin
         failures++;
         $display("FAIL mid_setup: got cnt=%0d we=%b%b busy34=%b required 2 11 1",
                  fifo_cnt_o, we_a_o, we_b_o, busy_o[34]);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({we_a_o, we_b_o, fifo_cnt_o, fpu_ready_o} !== 5'b00001 || busy_o !== 64'd0) begin
         failures++;
         $display("FAIL mid_async: got we=%b%b cnt=%0d fr=%b busy=%h required 00 0 1 0",
                  we_a_o, we_b_o, fifo_cnt_o, fpu_ready_o, busy_o);
      end
      step();
      #2 rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (we_a_o !== 1'b0 || fifo_cnt_o !== 2'd0) begin
            failures++;
            $display("FAIL mid_stale_%0d: got we_a=%b cnt=%0d required 0 0",
                     i, we_a_o, fifo_cnt_o);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rf[i] = 32'd0;
      rst_n = 1;
      idle_inputs();
      #1;
      test_reset();
      test_same_addr();
      test_fpu_single();
      test_full();
      test_set_clear();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
